// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared FSM state type, RISC-V funct3 codes, MMIO default and
// the request legality check for the data-memory access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [31:0] DISPLAY_ADDR_DEFAULT = 32'h7fe;

    // Illegal width code, or misaligned half/word; a store to the MMIO
    // display address is exempt from the alignment rule.
    function automatic logic access_error(input logic write, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [31:0] mmio);
        logic legal, misaligned;
        legal      = write ? (f3 inside {F3_SB, F3_SH, F3_SW})
                           : (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        misaligned = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        return !legal || (misaligned && !(write && addr == mmio));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane logic for word-only memory.
//   funct3     - access width/sign code
//   offset     - byte offset within the word (addr[1:0])
//   rdata      - word read from memory (old word for stores)
//   wdata      - store data, low bytes used for SB/SH
//   load_data  - selected lane, sign/zero extended
//   store_data - old word with the new lane(s) merged in (full wdata for SW)
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  sa;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] lane, bm, hm;

    always_comb begin
        sa         = {offset, 3'b000};
        b          = 8'(rdata >> sa);
        h          = 16'(rdata >> sa);
        lane       = wdata << sa;
        bm         = 32'h0000_00ff << sa;
        hm         = 32'h0000_ffff << sa;
        load_data  = funct3 == F3_LB  ? {{24{b[7]}}, b}  :
                     funct3 == F3_LH  ? {{16{h[15]}}, h} :
                     funct3 == F3_LBU ? {24'b0, b}       :
                     funct3 == F3_LHU ? {16'b0, h}       : rdata;
        store_data = funct3 == F3_SB ? (rdata & ~bm) | (lane & bm) :
                     funct3 == F3_SH ? (rdata & ~hm) | (lane & hm) : wdata;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store initiator turning RISC-V sub-word
// accesses into word-only memory reads/writes.
//   clk, reset, clk_enable            - clock, sync active-high reset, global advance
//   req_valid/ready/write/funct3/addr/wdata - request from execute stage
//   resp_valid/rdata/error            - one-cycle response (held while stalled)
//   mem_addr/wdata/we, mem_rdata      - word port to memory
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] DISPLAY_ADDR = DISPLAY_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(READ_LATENCY + 2);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          write_q;
    logic [31:0]   wdata_q, load_data, store_data;
    logic          mmio, err;

    mem_lane_align u_align (
        .funct3     (f3_q),
        .offset     (off_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        mmio   = req_write && req_addr == DISPLAY_ADDR;
        err    = access_error(req_write, req_funct3, req_addr, DISPLAY_ADDR);
        mem_we = state == S_WRITE && clk_enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cnt        <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
        end else if (clk_enable) begin
            case (state)
                S_IDLE: if (req_valid) begin
                    f3_q      <= req_funct3;
                    off_q     <= req_addr[1:0];
                    write_q   <= req_write;
                    wdata_q   <= req_wdata;
                    cnt       <= '0;
                    req_ready <= 1'b0;
                    mem_addr  <= mmio ? req_addr : {req_addr[31:2], 2'b00};
                    if (err) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= '0;
                    end else if (req_write && (req_funct3 == F3_SW || mmio)) begin
                        state     <= S_WRITE;
                        mem_wdata <= req_wdata;
                    end else begin
                        state <= S_READ;
                    end
                end
                // READ_LATENCY+1 edges here so mem_rdata is already valid when sampled.
                S_READ: if (cnt == CW'(READ_LATENCY)) begin
                    if (write_q) begin
                        state     <= S_WRITE;
                        mem_wdata <= store_data;
                    end else begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= load_data;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                S_WRITE: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven scoreboard bench for mem_access_unit with a
// two-cycle registered RAM model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, clk_enable = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_error, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM: address register then output register (READ_LATENCY = 2).
    logic [31:0] ram [256];
    logic [31:0] a1;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
            ram[8'h40] <= 32'h8899AABB;
            ram[8'h41] <= 32'h12345678;
            ram[8'h42] <= 32'hCAFEF00D;
        end else if (mem_we) begin
            ram[mem_addr[9:2]] <= mem_wdata;
        end
        a1        <= mem_addr;
        mem_rdata <= ram[a1[9:2]];
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        logic        err;
        int          lat, nwe;
        logic [31:0] waddr, wdat;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    vec_t        tbl[$];
    int          compared = 0, mismatched = 0, we_cnt = 0, we_stalled = 0;
    logic [31:0] last_wa = 32'd0, last_wd = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                                input int lat, input int nwe, input logic [31:0] waddr,
                                input logic [31:0] wdat);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.lat = lat; v.nwe = nwe; v.waddr = waddr; v.wdat = wdat;
        return v;
    endfunction

    // Write-strobe monitor and response scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) begin
            we_cnt++;
            last_wa = mem_addr;
            last_wd = mem_wdata;
            if (!clk_enable) we_stalled++;
        end
        if (!reset && resp_valid && clk_enable) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_error", 32'(resp_error), 32'(e.err));
            end
        end
    end

    // Issue one request; clk_enable is dropped in cycles stall_at+1..stall_at+stall_len.
    task automatic run(input vec_t v, input int stall_at, input int stall_len);
        int   n, we0;
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        we0 = we_cnt;
        e.rdata = v.rdata;
        e.err   = v.err;
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (n = 1; n <= 30; n++) begin
            clk_enable = !(n > stall_at && n <= stall_at + stall_len);
            @(negedge clk);
            if (resp_valid) break;
            @(posedge clk);
            #1;
        end
        if (n > 30) begin
            compared++;
            mismatched++;
            $display("FAIL resp_timeout: got no resp_valid in 30 cycles expected latency %0d", v.lat);
            exp_q.delete();
        end else begin
            check("latency", 32'(n), 32'(v.lat));
            check("req_ready_resp", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 clk_enable = 1'b1;
        check("we_cycles", 32'(we_cnt - we0), 32'(v.nwe));
        if (v.nwe > 0) begin
            check("mem_wdata", last_wd, v.wdat);
            check("mem_addr", last_wa, v.waddr);
        end
    endtask

    initial begin
        int rv;
        tbl.push_back(mk(0, F3_LB,  32'h102, 0, 32'hFFFFFF99, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, F3_LBU, 32'h102, 0, 32'h00000099, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, F3_LH,  32'h102, 0, 32'hFFFF8899, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, F3_LHU, 32'h100, 0, 32'h0000AABB, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, F3_LB,  32'h103, 0, 32'hFFFFFF88, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, F3_LBU, 32'h101, 0, 32'h000000AA, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, F3_LW,  32'h104, 0, 32'h12345678, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, F3_LW,  32'h102, 0, 32'h0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, F3_SH,  32'h103, 32'hFFFF, 32'h0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 3'd3,   32'h100, 0, 32'h0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3'd3,   32'h100, 32'h1, 32'h0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, F3_LH,  32'h101, 0, 32'h0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, F3_SW,  32'h102, 32'h5, 32'h0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, F3_SB,  32'h101, 32'h11, 32'h0, 0, 5, 1, 32'h100, 32'h889911BB));
        tbl.push_back(mk(0, F3_LW,  32'h100, 0, 32'h889911BB, 0, 4, 0, 0, 0));
        tbl.push_back(mk(1, F3_SH,  32'h106, 32'hBEEF, 32'h0, 0, 5, 1, 32'h104, 32'hBEEF5678));
        tbl.push_back(mk(0, F3_LH,  32'h106, 0, 32'hFFFFBEEF, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, F3_LHU, 32'h104, 0, 32'h00005678, 0, 4, 0, 0, 0));
        tbl.push_back(mk(1, F3_SW,  32'h7fe, 32'h00001234, 32'h0, 0, 2, 1, 32'h7fe, 32'h00001234));
        tbl.push_back(mk(1, F3_SW,  32'h108, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'h108, 32'hDEADBEEF));
        tbl.push_back(mk(0, F3_LW,  32'h108, 0, 32'hDEADBEEF, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, F3_LB,  32'h108, 0, 32'hFFFFFFEF, 0, 4, 0, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) run(tbl[i], 99, 0);

        // SH with clk_enable low for three cycles during its read phase.
        run(mk(1, F3_SH, 32'h100, 32'h00005555, 32'h0, 0, 8, 1, 32'h100, 32'h88995555), 1, 3);
        run(mk(0, F3_LW, 32'h100, 0, 32'h88995555, 0, 4, 0, 0, 0), 99, 0);
        check("we_while_stalled", 32'(we_stalled), 32'd0);

        // Reset asserted during the WRITE cycle of a SW aborts it without a response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_SW; req_addr = 32'h10C; req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_we_in_write", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid) rv++;
            @(negedge clk);
        end
        check("abort_no_resp", 32'(rv), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
